// File: rtl/myriadrf_rx_if.sv
`default_nettype none
// ============================================================================
// myriadrf_rx_if : pairs interleaved 12-bit I/Q RX words into 24-bit samples,
//                  queues them in a FWFT FIFO, counts drops and framing errors.
// Revision: 1.0
// ============================================================================
module myriadrf_rx_if #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic [11:0]      rxd,
  input  logic             rxiqsel,
  output logic [23:0]      m_data_o,
  output logic             m_valid_o,
  input  logic             m_ready_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] ovf_cnt_o,
  output logic [CNT_W-1:0] err_cnt_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [0:0] {
    WAIT_I = 1'b0,
    HAVE_I = 1'b1
  } state_t;

  logic [11:0]      rxd_q;
  logic             iqsel_q;
  state_t           state_q, state_d;
  logic [11:0]      i_q, i_d;
  logic             push;
  logic             err_inc;
  logic [23:0]      mem_q [DEPTH];
  logic [23:0]      mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic [23:0]      data_q, data_d;
  logic [CNT_W-1:0] ovf_q, ovf_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic             pop;
  logic             full;
  logic             wr_en;
  logic             ovf_inc;

  function automatic logic [CNT_W-1:0] sat_next(input logic [CNT_W-1:0] cur,
                                               input logic inc, input logic clr);
    logic [CNT_W-1:0] nxt;
    nxt = cur;
    if (clr)
      nxt = '0;
    else if (inc && (cur != CNT_MAX))
      nxt = cur + CNT_W'(1);
    return nxt;
  endfunction

  // Pairing FSM operates on the registered bus word, gated by the live enable.
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    push    = 1'b0;
    err_inc = 1'b0;
    if (!en_i) begin
      state_d = WAIT_I;
    end else begin
      case (state_q)
        WAIT_I: begin
          if (!iqsel_q) begin
            i_d     = rxd_q;
            state_d = HAVE_I;
          end else begin
            err_inc = 1'b1;
          end
        end
        HAVE_I: begin
          if (iqsel_q) begin
            push    = 1'b1;
            state_d = WAIT_I;
          end else begin
            i_d     = rxd_q;
            err_inc = 1'b1;
          end
        end
        default: state_d = WAIT_I;
      endcase
    end
  end

  assign m_valid_o = (cnt_q != '0);
  assign m_data_o  = data_q;
  assign ovf_cnt_o = ovf_q;
  assign err_cnt_o = err_q;

  // A pop in the same cycle frees the slot, so a push into a full FIFO survives.
  always_comb begin
    pop      = m_valid_o & m_ready_i;
    full     = (cnt_q == FULL_CNT);
    wr_en    = push & (~full | pop);
    ovf_inc  = push & full & ~pop;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (wr_en) begin
      mem_d[wr_ptr_q] = {i_q, rxd_q};
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop)
      rd_ptr_d = rd_ptr_q + AW'(1);
    case ({wr_en, pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
    // Output register tracks the next head so data holds once the FIFO empties.
    data_d = (cnt_d != '0) ? mem_d[rd_ptr_d] : data_q;
    ovf_d  = sat_next(ovf_q, ovf_inc, clr_i);
    err_d  = sat_next(err_q, err_inc, clr_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_q    <= '0;
      iqsel_q  <= 1'b0;
      state_q  <= WAIT_I;
      i_q      <= '0;
      for (int k = 0; k < DEPTH; k++)
        mem_q[k] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      data_q   <= '0;
      ovf_q    <= '0;
      err_q    <= '0;
    end else begin
      rxd_q    <= rxd;
      iqsel_q  <= rxiqsel;
      state_q  <= state_d;
      i_q      <= i_d;
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
    end
  end

endmodule
`default_nettype wire
